// File: rtl/fanout_eager_fork.sv
// Ready/valid broadcast fork: one upstream stream to NUM_SINKS sinks selected by cfg_en & cfg_sel.
// Lazy mode is all-or-nothing; eager mode tracks per-sink delivery so each sink takes the token once.
module fanout_eager_fork #(
    parameter int unsigned NUM_SINKS  = 9,
    parameter int unsigned DATA_WIDTH = 17,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic [NUM_SINKS-1:0]            cfg_en,
    input  logic [NUM_SINKS-1:0]            cfg_sel,
    input  logic                            cfg_eager,
    input  logic                            in_valid,
    input  logic [DATA_WIDTH-1:0]           in_data,
    output logic                            in_ready,
    output logic [NUM_SINKS-1:0]            out_valid,
    output logic [NUM_SINKS*DATA_WIDTH-1:0] out_data,
    input  logic [NUM_SINKS-1:0]            out_ready,
    output logic                            busy,
    output logic [CNT_WIDTH-1:0]            stall_cnt
);

    logic [NUM_SINKS-1:0] active;
    logic [NUM_SINKS-1:0] sink_ok;
    logic [NUM_SINKS-1:0] sink_fire;
    logic [NUM_SINKS-1:0] done_q, done_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic                 busy_q, busy_d;
    logic                 in_fire;
    logic                 others_ok;

    assign out_data = {NUM_SINKS{in_data}};

    // A sink is "ok" when it does not hold up the upstream handshake this cycle.
    always_comb begin
        active = cfg_en & cfg_sel;
        for (int unsigned i = 0; i < NUM_SINKS; i++) begin
            sink_ok[i] = ~active[i] | out_ready[i] | (cfg_eager & done_q[i]);
        end
        in_ready = &sink_ok;
    end

    // Lazy valid waits on every other active sink so that no sink fires unless all do.
    always_comb begin
        out_valid = '0;
        others_ok = 1'b1;
        for (int unsigned i = 0; i < NUM_SINKS; i++) begin
            if (cfg_eager) begin
                out_valid[i] = in_valid & active[i] & ~done_q[i];
            end else begin
                others_ok = 1'b1;
                for (int unsigned j = 0; j < NUM_SINKS; j++) begin
                    if (j != i) begin
                        others_ok = others_ok & sink_ok[j];
                    end
                end
                out_valid[i] = in_valid & active[i] & others_ok;
            end
        end
    end

    always_comb begin
        sink_fire = out_valid & out_ready;
        in_fire   = in_valid & in_ready;
        done_d    = '0;
        if (!(flush || in_fire) && cfg_eager) begin
            done_d = done_q | sink_fire;
        end
        busy_d = |done_d;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            stall_cnt_d = '0;
        end else if (in_valid && !in_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q      <= '0;
            busy_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            done_q      <= done_d;
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign busy      = busy_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fanout_eager_fork.sv
// Self-checking bench for fanout_eager_fork: vector table, directed corner sequences,
// and randomized eager-mode backpressure checked against a per-token delivery model.
module tb_fanout_eager_fork;

    localparam int NS = 9;
    localparam int DW = 17;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic [NS-1:0]     cfg_en = '0;
    logic [NS-1:0]     cfg_sel = '0;
    logic              cfg_eager = 1'b0;
    logic              in_valid = 1'b0;
    logic [DW-1:0]     in_data = '0;
    logic              in_ready;
    logic [NS-1:0]     out_valid;
    logic [NS*DW-1:0]  out_data;
    logic [NS-1:0]     out_ready = '0;
    logic              busy;
    logic [CW-1:0]     stall_cnt;

    int nvec = 0;
    int nerr = 0;
    int rx_cnt[NS];
    logic [DW-1:0] rx_last[NS];

    fanout_eager_fork #(
        .NUM_SINKS (NS),
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .cfg_en   (cfg_en),
        .cfg_sel  (cfg_sel),
        .cfg_eager(cfg_eager),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .busy     (busy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NS-1:0] en;
        logic [NS-1:0] sel;
        logic          eager;
        logic          valid;
        logic [NS-1:0] rdy;
        logic          exp_ir;
        logic [NS-1:0] exp_ov;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic do_flush;
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
    endtask

    task automatic clr_rx;
        for (int i = 0; i < NS; i++) begin
            rx_cnt[i]  = 0;
            rx_last[i] = '0;
        end
    endtask

    task automatic sample_rx;
        for (int i = 0; i < NS; i++) begin
            if (out_valid[i] && out_ready[i]) begin
                rx_cnt[i]++;
                rx_last[i] = out_data[i*DW +: DW];
            end
        end
    endtask

    task automatic chk_data(input string nm);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NS; i++) begin
            if (out_data[i*DW +: DW] !== in_data) ok = 1'b0;
        end
        chk(nm, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        logic [DW-1:0] txq[$];
        logic [DW-1:0] rxq[NS][$];
        logic [NS-1:0] taken;
        logic [NS-1:0] exp_ov;
        logic          exp_ir;
        logic          holding;
        int            cnt_m;
        int            sent;
        int            cyc;
        int            bad;

        // lazy: A = en & sel; out_valid[i] needs all other active sinks ready
        vecs[0]  = '{9'h1FF, 9'h1FF, 1'b0, 1'b1, 9'h1FF, 1'b1, 9'h1FF};
        vecs[1]  = '{9'h007, 9'h1FF, 1'b0, 1'b1, 9'h003, 1'b0, 9'h004};
        vecs[2]  = '{9'h007, 9'h1FF, 1'b0, 1'b1, 9'h007, 1'b1, 9'h007};
        vecs[3]  = '{9'h007, 9'h1FF, 1'b0, 1'b1, 9'h001, 1'b0, 9'h000};
        vecs[4]  = '{9'h00F, 9'h1FF, 1'b1, 1'b1, 9'h001, 1'b0, 9'h00F};
        vecs[5]  = '{9'h00F, 9'h1FF, 1'b1, 1'b1, 9'h00F, 1'b1, 9'h00F};
        vecs[6]  = '{9'h1FF, 9'h000, 1'b0, 1'b1, 9'h000, 1'b1, 9'h000};
        vecs[7]  = '{9'h1FF, 9'h000, 1'b1, 1'b1, 9'h000, 1'b1, 9'h000};
        vecs[8]  = '{9'h0F0, 9'h01F, 1'b0, 1'b1, 9'h010, 1'b1, 9'h010};
        vecs[9]  = '{9'h0F0, 9'h01F, 1'b0, 1'b1, 9'h000, 1'b0, 9'h010};
        vecs[10] = '{9'h0F0, 9'h01F, 1'b1, 1'b1, 9'h000, 1'b0, 9'h010};
        vecs[11] = '{9'h1FF, 9'h1FF, 1'b1, 1'b0, 9'h1FF, 1'b1, 9'h000};
        vecs[12] = '{9'h003, 9'h1FF, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000};

        // reset state
        rst_n = 1'b0;
        tick();
        tick();
        settle();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {28'd0, stall_cnt}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {23'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        tick();

        // table-driven combinational vectors, each from a flushed state
        for (int k = 0; k < 13; k++) begin
            do_flush();
            cfg_en    = vecs[k].en;
            cfg_sel   = vecs[k].sel;
            cfg_eager = vecs[k].eager;
            in_valid  = vecs[k].valid;
            in_data   = DW'(k * 17'h1111);
            out_ready = vecs[k].rdy;
            settle();
            chk($sformatf("vec%0d_in_ready", k), {31'd0, in_ready}, {31'd0, vecs[k].exp_ir});
            chk($sformatf("vec%0d_out_valid", k), {23'd0, out_valid}, {23'd0, vecs[k].exp_ov});
        end

        // lazy all-or-nothing delivery
        do_flush();
        cfg_en = 9'h007; cfg_sel = 9'h1FF; cfg_eager = 1'b0;
        clr_rx();
        in_valid = 1'b1; in_data = 17'h0ABCD; out_ready = 9'h003;
        settle();
        chk("lazy_stall_ir", {31'd0, in_ready}, 32'd0);
        chk("lazy_stall_ov", {23'd0, out_valid}, 32'h004);
        sample_rx();
        tick();
        chk("lazy_stall_cnt", {28'd0, stall_cnt}, 32'd1);
        out_ready = 9'h007;
        settle();
        chk("lazy_go_ir", {31'd0, in_ready}, 32'd1);
        chk("lazy_go_ov", {23'd0, out_valid}, 32'h007);
        chk_data("lazy_data");
        sample_rx();
        tick();
        in_valid = 1'b0;
        settle();
        sample_rx();
        chk("lazy_cnt_hold", {28'd0, stall_cnt}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lazy_rx_cnt%0d", i), rx_cnt[i], 32'd1);
            chk($sformatf("lazy_rx_data%0d", i), {15'd0, rx_last[i]}, 32'h0ABCD);
        end

        // eager per-sink tracking
        do_flush();
        cfg_en = 9'h00F; cfg_sel = 9'h1FF; cfg_eager = 1'b1;
        clr_rx();
        in_valid = 1'b1; in_data = 17'h00042; out_ready = 9'h001;
        settle();
        chk("eag_c0_ir", {31'd0, in_ready}, 32'd0);
        chk("eag_c0_busy", {31'd0, busy}, 32'd0);
        chk("eag_c0_ov", {23'd0, out_valid}, 32'h00F);
        sample_rx();
        tick();
        out_ready = 9'h004;
        settle();
        chk("eag_c1_ir", {31'd0, in_ready}, 32'd0);
        chk("eag_c1_busy", {31'd0, busy}, 32'd1);
        chk("eag_c1_ov", {23'd0, out_valid}, 32'h00E);
        sample_rx();
        tick();
        out_ready = 9'h00A;
        settle();
        chk("eag_c2_ir", {31'd0, in_ready}, 32'd1);
        chk("eag_c2_busy", {31'd0, busy}, 32'd1);
        chk("eag_c2_ov", {23'd0, out_valid}, 32'h00A);
        sample_rx();
        tick();
        in_valid = 1'b0; out_ready = '0;
        settle();
        chk("eag_c3_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("eag_rx_cnt%0d", i), rx_cnt[i], 32'd1);
            chk($sformatf("eag_rx_data%0d", i), {15'd0, rx_last[i]}, 32'h00042);
        end

        // empty active set drops tokens without stalling
        do_flush();
        cfg_en = '0; cfg_sel = '0; cfg_eager = 1'b1;
        for (int t = 0; t < 5; t++) begin
            in_valid = 1'b1; in_data = DW'($urandom); out_ready = NS'($urandom);
            settle();
            chk("empty_ir", {31'd0, in_ready}, 32'd1);
            chk("empty_ov", {23'd0, out_valid}, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        chk("empty_stall", {28'd0, stall_cnt}, 32'd0);

        // stall counter saturation and flush priority
        do_flush();
        cfg_en = 9'h1FF; cfg_sel = 9'h1FF; cfg_eager = 1'b1;
        in_valid = 1'b1; in_data = 17'h01234; out_ready = '0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("sat_cnt%0d", k), {28'd0, stall_cnt}, (k < 15) ? k : 15);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("sat_flush", {28'd0, stall_cnt}, 32'd0);
        tick();
        chk("sat_restart", {28'd0, stall_cnt}, 32'd1);
        in_valid = 1'b0;

        // async reset mid-token clears done at once
        do_flush();
        cfg_en = 9'h00F; cfg_sel = 9'h1FF; cfg_eager = 1'b1;
        in_valid = 1'b1; in_data = 17'h00155; out_ready = 9'h001;
        tick();
        out_ready = '0;
        settle();
        chk("rmid_ov", {23'd0, out_valid}, 32'h00E);
        chk("rmid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rmid_rst_ov", {23'd0, out_valid}, 32'h00F);
        chk("rmid_rst_busy", {31'd0, busy}, 32'd0);
        #1;
        rst_n = 1'b1;
        tick();

        // flush mid-token: same effect, one edge later
        out_ready = 9'h001;
        tick();
        out_ready = '0;
        settle();
        chk("fmid_ov", {23'd0, out_valid}, 32'h00E);
        flush = 1'b1;
        #1;
        chk("fmid_pre_ov", {23'd0, out_valid}, 32'h00E);
        tick();
        flush = 1'b0;
        settle();
        chk("fmid_post_ov", {23'd0, out_valid}, 32'h00F);
        chk("fmid_post_busy", {31'd0, busy}, 32'd0);

        // sinks firing together with the upstream fire do not set done
        out_ready = 9'h001;
        tick();
        out_ready = 9'h00E;
        settle();
        chk("fsim_ir", {31'd0, in_ready}, 32'd1);
        tick();
        in_data = 17'h00777; out_ready = '0;
        settle();
        chk("fsim_busy", {31'd0, busy}, 32'd0);
        chk("fsim_ov", {23'd0, out_valid}, 32'h00F);

        // flush coinciding with the upstream fire
        out_ready = 9'h001;
        tick();
        out_ready = 9'h00E; flush = 1'b1;
        settle();
        chk("ffire_ir", {31'd0, in_ready}, 32'd1);
        tick();
        flush = 1'b0; in_data = 17'h00888; out_ready = '0;
        settle();
        chk("ffire_busy", {31'd0, busy}, 32'd0);
        chk("ffire_ov", {23'd0, out_valid}, 32'h00F);
        in_valid = 1'b0;

        // randomized eager backpressure against a per-token delivery model
        do_flush();
        cfg_en = 9'h1FF; cfg_sel = 9'h1FF; cfg_eager = 1'b1;
        taken = '0; holding = 1'b0; cnt_m = 0; sent = 0; cyc = 0;
        while (sent < 1000 && cyc < 20000) begin
            cyc++;
            if (!holding) begin
                in_valid = ($urandom_range(3) != 0);
                in_data  = DW'($urandom);
                holding  = in_valid;
            end
            out_ready = NS'($urandom);
            settle();
            exp_ir = &(taken | out_ready);
            exp_ov = in_valid ? ~taken : '0;
            chk("rnd_in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
            chk("rnd_out_valid", {23'd0, out_valid}, {23'd0, exp_ov});
            chk_data("rnd_data");
            for (int i = 0; i < NS; i++) begin
                if (out_valid[i] && out_ready[i]) rxq[i].push_back(out_data[i*DW +: DW]);
            end
            if (in_valid && exp_ir) begin
                txq.push_back(in_data);
                sent++;
                taken   = '0;
                holding = 1'b0;
            end else if (in_valid) begin
                taken = taken | out_ready;
            end
            if (in_valid && !exp_ir && cnt_m != 15) cnt_m++;
            tick();
            chk("rnd_stall_cnt", {28'd0, stall_cnt}, cnt_m);
            chk("rnd_busy", {31'd0, busy}, {31'd0, |taken});
        end
        if (sent < 1000) chk("rnd_timeout", sent, 32'd1000);
        in_valid = 1'b0;
        for (int i = 0; i < NS; i++) begin
            chk($sformatf("sb_len%0d", i), rxq[i].size(), txq.size());
            bad = 0;
            for (int k = 0; k < txq.size() && k < rxq[i].size(); k++) begin
                if (rxq[i][k] !== txq[k]) bad++;
            end
            chk($sformatf("sb_data%0d", i), bad, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
